// File: rtl/oam_dma_controller.sv
// Sprite-memory DMA engine: a CPU write to the DMA register halts the CPU and
// copies one 256-byte page to the OAM data port as 256 read/write bus pairs.
`timescale 1ns/1ps
module oam_dma_controller #(
    parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cycleEn,
    input  logic [15:0] cpuAddress,
    input  logic [7:0]  cpuDataOut,
    input  logic        cpuRw,
    input  logic [7:0]  busDataIn,
    output logic [15:0] busAddress,
    output logic [7:0]  busDataOut,
    output logic        busRw,
    output logic        cpuHalt,
    output logic        dmaDone
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        parity;
    logic [7:0]  page;
    logic [7:0]  byteCount;
    logic [7:0]  dataLatch;
    logic        trigger;
    logic        last_byte;

    assign trigger   = (cpuRw == 1'b0) && (cpuAddress == DMA_REG_ADDR);
    assign last_byte = (byteCount == 8'hFF);
    assign cpuHalt   = (state != IDLE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else if (cycleEn) begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busAddress = cpuAddress;
        busDataOut = cpuDataOut;
        busRw      = cpuRw;
        case (state)
            IDLE: begin
                if (trigger) state_next = HALT;
            end
            HALT: begin
                busRw      = 1'b1;
                // Reads must start on an even cycle; odd HALT lets READ follow directly.
                state_next = parity ? READ : ALIGN;
            end
            ALIGN: begin
                busRw      = 1'b1;
                state_next = READ;
            end
            READ: begin
                busAddress = {page, byteCount};
                busRw      = 1'b1;
                state_next = WRITE;
            end
            WRITE: begin
                busAddress = OAM_DATA_ADDR;
                busDataOut = dataLatch;
                busRw      = 1'b0;
                state_next = last_byte ? IDLE : READ;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            parity    <= 1'b0;
            page      <= 8'h00;
            byteCount <= 8'h00;
            dataLatch <= 8'h00;
            dmaDone   <= 1'b0;
        end else begin
            dmaDone <= cycleEn && (state == WRITE) && last_byte;
            if (cycleEn) begin
                parity <= ~parity;
                case (state)
                    IDLE: begin
                        if (trigger) begin
                            page      <= cpuDataOut;
                            byteCount <= 8'h00;
                        end
                    end
                    READ:    dataLatch <= busDataIn;
                    WRITE:   byteCount <= byteCount + 8'd1;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_oam_dma_controller.sv
// Directed bench for oam_dma_controller: IDLE pass-through vector table plus
// full-transfer sequences (both alignments, stall, page FF, reset abort).
`timescale 1ns/1ps
module tb_oam_dma_controller;

    localparam logic [15:0] DMA = 16'h4014;
    localparam logic [15:0] OAM = 16'h2004;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        cycleEn = 1'b0;
    logic [15:0] cpuAddress = 16'h0000;
    logic [7:0]  cpuDataOut = 8'h00;
    logic        cpuRw = 1'b1;
    logic [7:0]  busDataIn = 8'h00;
    logic [15:0] busAddress;
    logic [7:0]  busDataOut;
    logic        busRw;
    logic        cpuHalt;
    logic        dmaDone;

    int   nvec = 0;
    int   nfail = 0;
    int   done_cnt = 0;
    logic tb_par = 1'b0;

    oam_dma_controller #(.DMA_REG_ADDR(DMA), .OAM_DATA_ADDR(OAM)) dut (
        .clock(clock), .reset(reset), .cycleEn(cycleEn),
        .cpuAddress(cpuAddress), .cpuDataOut(cpuDataOut), .cpuRw(cpuRw),
        .busDataIn(busDataIn), .busAddress(busAddress), .busDataOut(busDataOut),
        .busRw(busRw), .cpuHalt(cpuHalt), .dmaDone(dmaDone)
    );

    always #5 clock = ~clock;

    always @(negedge clock) if (dmaDone) done_cnt++;

    typedef struct {
        logic        en;
        logic [15:0] addr;
        logic [7:0]  data;
        logic        rw;
        logic [15:0] e_addr;
        logic [7:0]  e_data;
        logic        e_rw;
        logic        e_halt;
    } vec_t;

    function automatic logic [7:0] mem(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_cycle(input logic en);
        cycleEn = en;
        @(posedge clock);
        #1;
        cycleEn = 1'b0;
        if (en) tb_par = ~tb_par;
    endtask

    // Full transfer of page pg; trigger edge lands on parity trig_par.
    task automatic run_transfer(input logic [7:0] pg, input logic trig_par,
                                input int pause_at, input int abort_at);
        logic        al;
        int          exp_total;
        int          d0;
        int          k;
        int          j;
        logic [15:0] e_addr;
        logic [7:0]  e_data;
        logic        e_rw;
        logic        e_wr;
        cpuAddress = 16'h0000;
        cpuRw      = 1'b1;
        if (tb_par != trig_par) do_cycle(1'b1);
        cpuAddress = DMA;
        cpuDataOut = pg;
        cpuRw      = 1'b0;
        do_cycle(1'b1);
        cpuDataOut = ~pg;
        al        = ~tb_par;
        exp_total = al ? 514 : 513;
        d0        = done_cnt;
        chk("halt_start", cpuHalt, 1'b1);
        for (k = 0; k < 600; k++) begin
            if (!cpuHalt) break;
            e_wr   = 1'b0;
            e_data = 8'h00;
            if (k == 0 || (al && k == 1)) begin
                e_addr = DMA;
                e_rw   = 1'b1;
            end else begin
                j = k - 1 - int'(al);
                if (j % 2 == 0) begin
                    e_addr = {pg, 8'(j / 2)};
                    e_rw   = 1'b1;
                end else begin
                    e_addr = OAM;
                    e_rw   = 1'b0;
                    e_wr   = 1'b1;
                    e_data = mem({pg, 8'(j / 2)});
                end
            end
            chk($sformatf("addr_k%0d", k), busAddress, e_addr);
            chk($sformatf("rw_k%0d", k), busRw, e_rw);
            if (e_wr) chk($sformatf("wdata_k%0d", k), busDataOut, e_data);
            busDataIn = mem(e_addr);
            if (k == abort_at) begin
                reset = 1'b0;
                #1;
                chk("abort_halt", cpuHalt, 1'b0);
                chk("abort_addr", busAddress, DMA);
                chk("abort_rw", busRw, 1'b0);
                cycleEn = 1'b1;
                @(posedge clock);
                @(posedge clock);
                #1;
                cycleEn = 1'b0;
                chk("abort_addr_held", busAddress, DMA);
                reset  = 1'b1;
                tb_par = 1'b0;
                chk("abort_no_done", dmaDone, 1'b0);
                chk("abort_done_cnt", done_cnt, d0);
                return;
            end
            if (k == pause_at) begin
                repeat (10) @(posedge clock);
                #1;
                chk("pause_addr", busAddress, e_addr);
                chk("pause_halt", cpuHalt, 1'b1);
                chk("pause_done", dmaDone, 1'b0);
            end
            do_cycle(1'b1);
        end
        chk("total_strobes", k, exp_total);
        chk("end_halt", cpuHalt, 1'b0);
        chk("done_pulse", dmaDone, 1'b1);
        do_cycle(1'b0);
        chk("done_clear", dmaDone, 1'b0);
        chk("done_count", done_cnt, d0 + 1);
        cpuAddress = 16'h0000;
        cpuRw      = 1'b1;
    endtask

    vec_t vt[6];

    initial begin
        vt[0] = '{1'b1, 16'h4013, 8'h02, 1'b0, 16'h4013, 8'h02, 1'b0, 1'b0};
        vt[1] = '{1'b1, 16'h4015, 8'h02, 1'b0, 16'h4015, 8'h02, 1'b0, 1'b0};
        vt[2] = '{1'b1, 16'h4014, 8'h02, 1'b1, 16'h4014, 8'h02, 1'b1, 1'b0};
        vt[3] = '{1'b0, 16'h4014, 8'h02, 1'b0, 16'h4014, 8'h02, 1'b0, 1'b0};
        vt[4] = '{1'b1, 16'h0000, 8'hAA, 1'b0, 16'h0000, 8'hAA, 1'b0, 1'b0};
        vt[5] = '{1'b1, 16'hFFFF, 8'h55, 1'b1, 16'hFFFF, 8'h55, 1'b1, 1'b0};

        cpuAddress = 16'h1234;
        cpuDataOut = 8'h9C;
        #12;
        chk("rst_halt", cpuHalt, 1'b0);
        chk("rst_done", dmaDone, 1'b0);
        chk("rst_addr", busAddress, 16'h1234);
        chk("rst_data", busDataOut, 8'h9C);
        @(posedge clock);
        #1;
        reset  = 1'b1;
        tb_par = 1'b0;

        for (int i = 0; i < 6; i++) begin
            cpuAddress = vt[i].addr;
            cpuDataOut = vt[i].data;
            cpuRw      = vt[i].rw;
            #1;
            chk($sformatf("v%0d_addr", i), busAddress, vt[i].e_addr);
            chk($sformatf("v%0d_data", i), busDataOut, vt[i].e_data);
            chk($sformatf("v%0d_rw", i), busRw, vt[i].e_rw);
            do_cycle(vt[i].en);
            chk($sformatf("v%0d_halt", i), cpuHalt, vt[i].e_halt);
            chk($sformatf("v%0d_addr_post", i), busAddress, vt[i].e_addr);
        end

        // HALT on odd parity: 513 strobes.
        run_transfer(8'h02, 1'b0, -1, -1);
        // HALT on even parity: ALIGN inserted, 514 strobes, with a mid-transfer stall.
        run_transfer(8'h02, 1'b1, 200, -1);
        // Top page: reads run up to 16'hFFFF.
        run_transfer(8'hFF, 1'b0, -1, -1);
        // Abort during WRITE of byte 8'h40 (HALT even -> ALIGN, so k = 1+1+128+1).
        run_transfer(8'h03, 1'b1, -1, 131);
        // First edge after reset is parity 0, so this transfer takes 513 strobes.
        run_transfer(8'h03, 1'b0, -1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
